// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared opcode, state and datapath-select encodings for the multi-cycle RV32I core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

  // Base opcodes (inst[6:0]) recognised by the control path
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // FSM encoding is visible on the debug state port, so values are fixed
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_sel_e;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // One-hot instruction class; legal is the OR of the class flags
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
    logic is_op;
    logic is_opimm;
    logic legal;
  } opclass_t;

endpackage

// File: rtl/rv_opclass.sv
// rv_opclass: combinational decode of inst[6:0] into one-hot instruction class flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module rv_opclass
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opclass_t   cls_o
);

  // Map the opcode to exactly one class flag; unknown opcodes leave all flags clear
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OPC_LOAD:   cls_o.is_load   = 1'b1;
      OPC_STORE:  cls_o.is_store  = 1'b1;
      OPC_BRANCH: cls_o.is_branch = 1'b1;
      OPC_JAL:    cls_o.is_jal    = 1'b1;
      OPC_JALR:   cls_o.is_jalr   = 1'b1;
      OPC_LUI:    cls_o.is_lui    = 1'b1;
      OPC_AUIPC:  cls_o.is_auipc  = 1'b1;
      OPC_OP:     cls_o.is_op     = 1'b1;
      OPC_OPIMM:  cls_o.is_opimm  = 1'b1;
      default:    cls_o           = '0;
    endcase
    cls_o.legal = cls_o.is_load | cls_o.is_store | cls_o.is_branch | cls_o.is_jal |
                  cls_o.is_jalr | cls_o.is_lui | cls_o.is_auipc | cls_o.is_op | cls_o.is_opimm;
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle RV32I control FSM driving datapath selects, enables and the memory handshake.
// Latency: branch 3, ALU/LUI/AUIPC/jump/store 4, load 5 cycles with zero-wait memory.
// Backpressure: FETCH/MEM hold until mem_ready; MEM_TIMEOUT>0 halts with sticky bus_err.
// Build option RV_MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt and set the sticky illegal_op port.
module rv_mc_ctrl
  import rv32i_pkg::*;
#(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  input  logic                 mem_ready,
  input  logic                 br_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_ifetch,
  output logic                 ir_we,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [1:0]           alu_a_sel,
  output logic                 alu_b_sel,
  output logic [1:0]           wb_sel,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 bus_err
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_op
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 bus_err_q, bus_err_d;
  opclass_t             cls;
  logic                 in_wait, timeout, retire;

  // Upper IR bits feed the immediate generator and ALU decode, not this FSM
  logic unused_inst_hi;
  assign unused_inst_hi = ^inst[31:7];

  rv_opclass u_opclass (
    .opcode_i (inst[6:0]),
    .cls_o    (cls)
  );

  // Wait counter runs only while a request is outstanding without ready
  assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_d  = (in_wait && !mem_ready) ? wait_q + 1'b1 : '0;
  assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                   (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // A legal instruction retires on the cycle that commits its PC update
  assign retire    = pc_we && cls.legal;
  assign instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
  assign bus_err_d = bus_err_q | timeout;

  // State register plus the registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  // Sticky flag for an illegal opcode seen in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if ((state_q == ST_DECODE) && !cls.legal) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal_op = illegal_q;
`endif

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (timeout)        state_d = ST_HALT;
        else if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls.legal) state_d = ST_EXEC;
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
        else           state_d = ST_HALT;
`else
        else           state_d = ST_FETCH;
`endif
      end
      ST_EXEC: begin
        if (cls.is_load || cls.is_store) state_d = ST_MEM;
        else if (cls.is_branch)          state_d = ST_FETCH;
        else if (cls.is_op || cls.is_opimm || cls.is_lui || cls.is_auipc ||
                 cls.is_jal || cls.is_jalr) state_d = ST_WB;
        else                             state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (timeout)        state_d = ST_HALT;
        else if (mem_ready) state_d = cls.is_store ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath selects and strobes; strobes forced low while reset is asserted
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_ifetch = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    wb_sel     = WB_ALU;
    // Operand selects follow the class in every state so alu_y stays valid into MEM/WB
    alu_a_sel  = cls.is_lui ? ALU_A_ZERO : (cls.is_auipc ? ALU_A_PC : ALU_A_RS1);
    alu_b_sel  = (cls.is_opimm || cls.is_load || cls.is_store || cls.is_jalr ||
                  cls.is_lui || cls.is_auipc) ? ALU_B_IMM : ALU_B_RS2;
    case (state_q)
      ST_FETCH: begin
        mem_req    = 1'b1;
        mem_ifetch = 1'b1;
        ir_we      = mem_ready;
      end
      ST_DECODE: begin
`ifndef RV_MC_CTRL_ILLEGAL_TRAP_EN
        pc_we = !cls.legal;
`endif
      end
      ST_EXEC: begin
        if (cls.is_branch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PC_IMM : PC_PLUS4;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls.is_store;
        pc_we   = mem_ready && cls.is_store;
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        wb_sel = cls.is_load ? WB_MEM : ((cls.is_jal || cls.is_jalr) ? WB_PC4 : WB_ALU);
        pc_sel = cls.is_jal ? PC_IMM : (cls.is_jalr ? PC_ALU : PC_PLUS4);
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      rf_we   = 1'b0;
      pc_we   = 1'b0;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign halted  = (state_q == ST_HALT);
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb_rv_mc_ctrl: directed plus randomized instruction stream against a per-instruction cycle model.
// Latency: n/a.
// Backpressure: bench drives mem_ready stalls up to 3 cycles and one full timeout.
module tb_rv_mc_ctrl;

  localparam int TMO = 4;

  localparam logic [6:0] O_LOAD  = 7'h03;
  localparam logic [6:0] O_OPIMM = 7'h13;
  localparam logic [6:0] O_AUIPC = 7'h17;
  localparam logic [6:0] O_STORE = 7'h23;
  localparam logic [6:0] O_OP    = 7'h33;
  localparam logic [6:0] O_LUI   = 7'h37;
  localparam logic [6:0] O_BR    = 7'h63;
  localparam logic [6:0] O_JALR  = 7'h67;
  localparam logic [6:0] O_JAL   = 7'h6f;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        mem_ready, br_taken;
  logic        mem_req, mem_we, mem_ifetch, ir_we, rf_we, pc_we, alu_b_sel, halted, bus_err;
  logic [1:0]  pc_sel, alu_a_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  always #5 clk = ~clk;

  rv_mc_ctrl #(.INSTRET_W(32), .MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .mem_ready  (mem_ready),
    .br_taken   (br_taken),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ifetch (mem_ifetch),
    .ir_we      (ir_we),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .wb_sel     (wb_sel),
    .state      (state),
    .instret    (instret),
    .halted     (halted),
    .bus_err    (bus_err)
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = '0;

  // One expected cycle: state, strobes {mem_req,mem_we,ir_we,rf_we,pc_we}, selects (-1 = don't care)
  typedef struct {
    int       st;
    bit       rdy;
    bit [4:0] strb;
    int       pcs;
    int       wbs;
    int       as;
    int       bs;
  } step_t;
  step_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({mem_req, mem_we, ir_we, rf_we, pc_we});
  endfunction

  function automatic step_t mk(int st, bit rdy, bit [4:0] strb,
                               int pcs = -1, int wbs = -1, int as = -1, int bs = -1);
    step_t s;
    s.st = st; s.rdy = rdy; s.strb = strb; s.pcs = pcs; s.wbs = wbs; s.as = as; s.bs = bs;
    return s;
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    return op inside {O_LOAD, O_OPIMM, O_AUIPC, O_STORE, O_OP, O_LUI, O_BR, O_JALR, O_JAL};
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, straight from the state rules
  function automatic void build(logic [6:0] op, int fw, int mw, bit br);
    bit ld  = (op == O_LOAD);
    bit stv = (op == O_STORE);
    bit bra = (op == O_BR);
    int as, bs, wbs, pcs;
    q.delete();
    for (int i = 0; i < fw; i++) q.push_back(mk(0, 1'b0, 5'b10000));
    q.push_back(mk(0, 1'b1, 5'b10100));
    if (!is_legal(op)) begin
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
      q.push_back(mk(1, 1'b0, 5'b00000));
`else
      q.push_back(mk(1, 1'b0, 5'b00001, 0));
`endif
      return;
    end
    q.push_back(mk(1, 1'b0, 5'b00000));
    case (op)
      O_LUI:                           begin as = 2;  bs = 1;  end
      O_AUIPC:                         begin as = 1;  bs = 1;  end
      O_OP, O_BR:                      begin as = 0;  bs = 0;  end
      O_JAL:                           begin as = -1; bs = -1; end
      default:                         begin as = 0;  bs = 1;  end
    endcase
    wbs = ld ? 1 : ((op == O_JAL || op == O_JALR) ? 2 : 0);
    pcs = (op == O_JAL) ? 1 : ((op == O_JALR) ? 2 : 0);
    if (bra) q.push_back(mk(2, 1'b0, 5'b00001, br ? 1 : 0, -1, as, bs));
    else     q.push_back(mk(2, 1'b0, 5'b00000, -1, -1, as, bs));
    if (ld || stv) begin
      for (int i = 0; i < mw; i++) q.push_back(mk(3, 1'b0, {1'b1, stv, 3'b000}));
      q.push_back(mk(3, 1'b1, {1'b1, stv, 2'b00, stv}, stv ? 0 : -1));
    end
    if (!bra && !stv) q.push_back(mk(4, 1'b0, 5'b00011, pcs, wbs));
  endfunction

  // Called at posedge+1 with the FSM in FETCH; returns at posedge+1 after the instruction
  task automatic run(input logic [31:0] iw, input int fw, input int mw, input bit br, input string nm);
    bit exp_halt;
    build(iw[6:0], fw, mw, br);
    inst = iw;
    foreach (q[k]) begin
      mem_ready = (q[k].st == 0 || q[k].st == 3) ? q[k].rdy : 1'($urandom);
      br_taken  = (q[k].st == 2) ? br : 1'($urandom);
      @(negedge clk);
      chk({nm, " state"}, 32'(state), 32'(q[k].st));
      chk({nm, " strobes"}, strobes(), 32'(q[k].strb));
      if (q[k].strb[4]) chk({nm, " ifetch"}, 32'(mem_ifetch), 32'(q[k].st == 0));
      if (q[k].pcs >= 0) chk({nm, " pc_sel"}, 32'(pc_sel), 32'(q[k].pcs));
      if (q[k].wbs >= 0) chk({nm, " wb_sel"}, 32'(wb_sel), 32'(q[k].wbs));
      if (q[k].as >= 0) begin
        chk({nm, " alu_a_sel"}, 32'(alu_a_sel), 32'(q[k].as));
        chk({nm, " alu_b_sel"}, 32'(alu_b_sel), 32'(q[k].bs));
      end
      @(posedge clk); #1;
    end
    if (is_legal(iw[6:0])) exp_instret = exp_instret + 1;
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
    exp_halt = !is_legal(iw[6:0]);
`else
    exp_halt = 1'b0;
`endif
    chk({nm, " instret"}, instret, exp_instret);
    chk({nm, " halted"}, 32'(halted), 32'(exp_halt));
    chk({nm, " next state"}, 32'(state), exp_halt ? 32'd7 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [9];
    ops = '{O_LOAD, O_OPIMM, O_AUIPC, O_STORE, O_OP, O_LUI, O_BR, O_JALR, O_JAL};

    // Reset: mem_ready high must not leak through to any strobe
    rst_n = 1'b0; inst = 32'h0000_0013; mem_ready = 1'b1; br_taken = 1'b0;
    #2;
    chk("rst state", 32'(state), 32'd0);
    chk("rst strobes", strobes(), 32'd0);
    chk("rst instret", instret, 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
    chk("rst illegal_op", 32'(illegal_op), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("release state", 32'(state), 32'd0);

    // Directed instructions
    run(32'hf8010113, 0, 0, 1'b0, "addi");
    run(32'h0187a783, 0, 2, 1'b0, "lw");
    run(32'h06112e23, 1, 1, 1'b0, "sw");
    run(32'h00f71a63, 0, 0, 1'b1, "bne_t");
    run(32'h00f71a63, 0, 0, 1'b0, "bne_nt");
    run(32'h010000ef, 0, 0, 1'b0, "jal");
    run(32'h00008067, 2, 0, 1'b0, "jalr");

    // Random legal stream with short stalls (below the timeout)
    for (int n = 0; n < 60; n++) begin
      logic [31:0] w;
      w = ($urandom() & 32'hFFFF_FF80) | 32'(ops[$urandom_range(0, 8)]);
      run(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "rand");
    end

    // Reset in the middle of a MEM wait
    inst = 32'h0187a783; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("midmem state", 32'(state), 32'd3);
    chk("midmem mem_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_instret = '0;
    chk("midmem rst state", 32'(state), 32'd0);
    chk("midmem rst strobes", strobes(), 32'd0);
    chk("midmem rst instret", instret, exp_instret);
    @(posedge clk); #1;
    chk("midmem hold strobes", strobes(), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midmem release state", 32'(state), 32'd0);
    chk("midmem release strobes", strobes(), 32'b10100);
    mem_ready = 1'b0;

    // Fetch timeout: four not-ready cycles halt with bus_err
    repeat (3) @(posedge clk);
    #1;
    chk("tmo 3 halted", 32'(halted), 32'd0);
    chk("tmo 3 bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    chk("tmo 4 halted", 32'(halted), 32'd1);
    chk("tmo 4 bus_err", 32'(bus_err), 32'd1);
    chk("tmo 4 state", 32'(state), 32'd7);
    chk("tmo 4 strobes", strobes(), 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("tmo stuck halted", 32'(halted), 32'd1);
    chk("tmo stuck strobes", strobes(), 32'd0);
    chk("tmo stuck bus_err", 32'(bus_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("tmo rst bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Illegal opcode after one retired instruction
    run(32'hf8010113, 0, 0, 1'b0, "addi2");
    run(32'h0000_0000, 0, 0, 1'b0, "illegal");
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
    chk("illegal_op set", 32'(illegal_op), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("illegal hold state", 32'(state), 32'd7);
    chk("illegal hold instret", instret, exp_instret);
    rst_n = 1'b0;
    #1;
    chk("illegal rst clear", 32'(illegal_op), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`else
    run(32'h00000013, 0, 0, 1'b0, "after_nop");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I datapath: PC, instruction register (IR), register file, ALU, immediate generator and a shared single-port memory.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the memory request handshake.
- Produces all datapath mux selects and write enables, and counts retired instructions.
- Decodes only inst[6:0]. The immediate generator and ALU decode consume the IR directly.

Parameters:
INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W).
MEM_TIMEOUT, 0, max wait cycles for mem_ready in FETCH/MEM; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst  in  32  IR contents; stable from DECODE to instruction end
mem_ready  in  1  memory completes the current request this cycle
br_taken  in  1  branch comparison result from ALU, valid in EXEC
mem_req  out  1  memory request (FETCH or MEM)
mem_we  out  1  store request (MEM of STORE only)
mem_ifetch  out  1  1 = address from PC, 0 = address from ALU result register
ir_we  out  1  capture memory rdata into IR
rf_we  out  1  register file write
pc_we  out  1  PC update
pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = {alu_y[31:1],1'b0}
alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
alu_b_sel  out  1  0 = rs2, 1 = imm
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
state  out  3  current state (debug)
instret  out  INSTRET_W  retired-instruction count
halted  out  1  FSM is in HALT
bus_err  out  1  sticky; memory timeout occurred

Behaviour:
Reset (async, rst_n=0):
- State goes to FETCH; instret=0; bus_err=0.
- All strobes are 0 while rst_n=0. Combinational outputs follow state once released.
- Reset mid-MEM aborts the access; no rf_we or pc_we is issued.

State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Outputs are combinational from state, inst[6:0], mem_ready and br_taken.
- No registered output except instret, bus_err and state.

FETCH:
- mem_req=1, mem_ifetch=1.
- Holds until mem_ready=1. In that cycle ir_we=1, next state DECODE.

DECODE:
- One cycle. Legal opcodes go to EXEC.
- Legal opcodes: LOAD 0000011, OP-IMM 0010011, AUIPC 0010111, STORE 0100011, OP 0110011, LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111.

EXEC:
- OP: a=rs1, b=rs2, then WB.
- OP-IMM, LOAD, STORE, JALR: a=rs1, b=imm. OP-IMM and JALR go to WB; LOAD and STORE go to MEM.
- LUI: a=zero, b=imm, then WB.
- AUIPC: a=PC, b=imm, then WB.
- BRANCH: a=rs1, b=rs2. Sets pc_we=1 and pc_sel = br_taken ? 1 : 0. Retires, then FETCH.
- JAL: next state WB.

MEM:
- mem_req=1, mem_ifetch=0, mem_we = (STORE).
- Holds until mem_ready.
- STORE on ready: pc_we=1, pc_sel=0, retire, then FETCH.
- LOAD on ready: next state WB.

WB:
- rf_we=1 and pc_we=1, then FETCH; retire.
- wb_sel: LOAD=1; JAL and JALR=2; otherwise 0.
- pc_sel: JAL=1; JALR=2; otherwise 0.

Retire: instret increments by 1 in the cycle pc_we=1 for a legal instruction.

Timeout (MEM_TIMEOUT>0):
- An internal wait counter clears on entry to FETCH/MEM and counts cycles with mem_ready=0.
- When it reaches MEM_TIMEOUT: bus_err<=1, state goes to HALT, no strobes issued.

HALT:
- All strobes 0, halted=1.
- Exit only by reset.

Latency with zero-wait memory (mem_ready=1 on the first request cycle):
- ALU, LUI/AUIPC and jumps: 4 cycles.
- BRANCH: 3 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.

Optional Feature:
RV_MC_CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to HALT, sets sticky output illegal_op=1 (extra 1-bit port), and does not increment instret.
- Undefined: an illegal opcode is a NOP. DECODE asserts pc_we=1, pc_sel=0, then FETCH; instret is not incremented; the illegal_op port is absent.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants for the 9 opcodes above;
  - state encoding;
  - pc_sel, alu_a_sel and wb_sel encodings.
- Natural sub-module: rv_opclass, a combinational decoder from inst[6:0] to one-hot class flags (is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_op, is_opimm, legal). It is shared with the immediate generator checks.

Test Plan:
- addi 0xf8010113, mem_ready tied 1 -> states 0,1,2,4,0.
  - WB cycle: rf_we=1, pc_we=1, wb_sel=0, pc_sel=0.
  - instret=1 after 4 cycles.
- lw 0x0187a783, mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles with mem_we=0, then WB with wb_sel=1; total 7 cycles.
- sw 0x06112e23 -> mem_we=1 only in MEM; rf_we never 1; pc_we on the ready cycle.
- bne 0x00f71a63 with br_taken=1, then again with 0 -> EXEC pc_sel=1 then 0; both 3 cycles; instret +2.
- jal 0x010000ef, then jalr 0x00008067 -> WB wb_sel=2 for both; pc_sel=1 then 2.
- Illegal 0x00000000 -> macro on: HALT, illegal_op=1, instret unchanged; macro off: DECODE pc_we=1, then FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err=1 and halted=1 after 4 cycles.
- rst_n low mid-MEM -> state returns to FETCH, instret=0, no strobes.
